// File: rtl/aux_cmd_pkg.sv
// Shared constants and state types for the auxiliary-link command engine.
// Header layout: [31:28] opcode, [27:16] word count, [15:0] start address.
package aux_cmd_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_READ  = 4'd2;

  // Bit positions inside the 16-bit trailer status field.
  localparam int ST_BAD_OP   = 0;
  localparam int ST_TIMEOUT  = 1;
  localparam int ST_ZERO_CNT = 2;

  localparam logic [31:0] FILL_WORD = 32'hDEAD_DEAD;

  localparam int HDR_OP_MSB   = 31;
  localparam int HDR_OP_LSB   = 28;
  localparam int HDR_CNT_MSB  = 27;
  localparam int HDR_CNT_LSB  = 16;
  localparam int HDR_ADDR_MSB = 15;
  localparam int HDR_ADDR_LSB = 0;

  typedef enum logic [2:0] {
    S_FETCH_HDR,
    S_DECODE,
    S_FETCH_DATA,
    S_REG_WR,
    S_REG_RD,
    S_SEND_DATA,
    S_SEND_TRAIL
  } main_state_e;

  typedef enum logic [1:0] {
    L_IDLE,
    L_REQ,
    L_WAIT1,
    L_WAIT
  } link_state_e;

  function automatic logic op_is_valid(input logic [3:0] op);
    return (op == OP_NOP) || (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/aux_cmd_engine_if.sv
// Bundles the aux_io link and local register-bus signals of the command engine.
// master = engine side, slave = aux_io / register-file side.
interface aux_cmd_engine_if;
  logic        aux_read_req;
  logic        aux_write_req;
  logic [31:0] aux_data_write;
  logic [16:0] aux_address;
  logic [31:0] aux_data_read;
  logic        aux_busy;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  modport master (
    output aux_read_req, aux_write_req, aux_data_write, aux_address,
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  aux_data_read, aux_busy, reg_rdata, reg_ack
  );

  modport slave (
    input  aux_read_req, aux_write_req, aux_data_write, aux_address,
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output aux_data_read, aux_busy, reg_rdata, reg_ack
  );
endinterface

// File: rtl/aux_link_master.sv
// One-word handshake with aux_io: wait idle, pulse request, skip one cycle, wait busy low.
// A start pulse is latched and issued once aux_io reports not busy.
module aux_link_master
  import aux_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_start,
  input  logic        wr_start,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        aux_read_req,
  output logic        aux_write_req,
  output logic [31:0] aux_data_write,
  input  logic [31:0] aux_data_read,
  input  logic        aux_busy
);

  link_state_e state_reg;
  logic        pending_reg;
  logic        is_wr_reg;
  logic        done_reg;
  logic [31:0] rdata_reg;
  logic        rd_req_reg;
  logic        wr_req_reg;
  logic [31:0] wdata_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= L_IDLE;
      pending_reg <= 1'b0;
      is_wr_reg   <= 1'b0;
      done_reg    <= 1'b0;
      rdata_reg   <= '0;
      rd_req_reg  <= 1'b0;
      wr_req_reg  <= 1'b0;
      wdata_reg   <= '0;
    end else begin
      done_reg   <= 1'b0;
      rd_req_reg <= 1'b0;
      wr_req_reg <= 1'b0;
      case (state_reg)
        L_IDLE: begin
          if (rd_start || wr_start) begin
            pending_reg <= 1'b1;
            is_wr_reg   <= wr_start;
            if (wr_start) wdata_reg <= wdata;
          end else if (pending_reg && !aux_busy) begin
            pending_reg <= 1'b0;
            state_reg   <= L_REQ;
            if (is_wr_reg) wr_req_reg <= 1'b1;
            else           rd_req_reg <= 1'b1;
          end
        end
        L_REQ:   state_reg <= L_WAIT1;
        // aux_io raises busy during this cycle, so it is not sampled here.
        L_WAIT1: state_reg <= L_WAIT;
        L_WAIT: begin
          if (!aux_busy) begin
            if (!is_wr_reg) rdata_reg <= aux_data_read;
            done_reg  <= 1'b1;
            state_reg <= L_IDLE;
          end
        end
        default: state_reg <= L_IDLE;
      endcase
    end
  end

  assign done           = done_reg;
  assign rdata          = rdata_reg;
  assign aux_read_req   = rd_req_reg;
  assign aux_write_req  = wr_req_reg;
  assign aux_data_write = wdata_reg;

endmodule

// File: rtl/aux_cmd_engine.sv
// Host command initiator: fetches header/data words from aux_io, runs single-beat
// register transactions, and returns readback words plus a status trailer.
module aux_cmd_engine
  import aux_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  aux_cmd_engine_if.master bus,
  output logic [15:0]      cmd_count,
  output logic             err_flag
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  main_state_e state_reg;
  logic [31:0] hdr_reg;
  logic [31:0] reply_reg;
  logic [31:0] link_wdata_reg;
  logic [31:0] reg_wdata_reg;
  logic [15:0] addr_reg;
  logic [15:0] status_reg;
  logic [15:0] tmo_cnt_reg;
  logic [15:0] cmd_count_reg;
  logic [11:0] word_cnt_reg;
  logic        link_issued_reg;
  logic        rd_start_reg;
  logic        wr_start_reg;
  logic        reg_we_reg;
  logic        reg_re_reg;
  logic        err_flag_reg;
  logic        link_done;
  logic [31:0] link_rdata;
  logic [3:0]  hdr_op;
  logic [11:0] hdr_cnt;
  logic        last_word;
  logic        bus_done;

  assign hdr_op    = hdr_reg[HDR_OP_MSB:HDR_OP_LSB];
  assign hdr_cnt   = hdr_reg[HDR_CNT_MSB:HDR_CNT_LSB];
  assign last_word = (word_cnt_reg + 12'd1) == hdr_cnt;
  // Ack wins over the timeout limit when both land on the same cycle.
  assign bus_done  = bus.reg_ack || (tmo_cnt_reg == TMO_LAST);

  aux_link_master u_link (
    .clk            (clk),
    .reset          (reset),
    .rd_start       (rd_start_reg),
    .wr_start       (wr_start_reg),
    .wdata          (link_wdata_reg),
    .done           (link_done),
    .rdata          (link_rdata),
    .aux_read_req   (bus.aux_read_req),
    .aux_write_req  (bus.aux_write_req),
    .aux_data_write (bus.aux_data_write),
    .aux_data_read  (bus.aux_data_read),
    .aux_busy       (bus.aux_busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_FETCH_HDR;
      hdr_reg         <= '0;
      reply_reg       <= '0;
      link_wdata_reg  <= '0;
      reg_wdata_reg   <= '0;
      addr_reg        <= '0;
      status_reg      <= '0;
      tmo_cnt_reg     <= '0;
      cmd_count_reg   <= '0;
      word_cnt_reg    <= '0;
      link_issued_reg <= 1'b0;
      rd_start_reg    <= 1'b0;
      wr_start_reg    <= 1'b0;
      reg_we_reg      <= 1'b0;
      reg_re_reg      <= 1'b0;
      err_flag_reg    <= 1'b0;
    end else begin
      rd_start_reg <= 1'b0;
      wr_start_reg <= 1'b0;
      case (state_reg)
        S_FETCH_HDR: begin
          if (!link_issued_reg) begin
            rd_start_reg    <= 1'b1;
            link_issued_reg <= 1'b1;
          end else if (link_done) begin
            link_issued_reg <= 1'b0;
            hdr_reg         <= link_rdata;
            status_reg      <= '0;
            state_reg       <= S_DECODE;
          end
        end
        S_DECODE: begin
          addr_reg     <= hdr_reg[HDR_ADDR_MSB:HDR_ADDR_LSB];
          word_cnt_reg <= '0;
          if (!op_is_valid(hdr_op)) begin
            status_reg[ST_BAD_OP] <= 1'b1;
            state_reg             <= S_SEND_TRAIL;
          end else if (hdr_op == OP_NOP) begin
            state_reg <= S_SEND_TRAIL;
          end else if (hdr_cnt == 12'd0) begin
            status_reg[ST_ZERO_CNT] <= 1'b1;
            state_reg               <= S_SEND_TRAIL;
          end else begin
            state_reg <= (hdr_op == OP_WRITE) ? S_FETCH_DATA : S_REG_RD;
          end
        end
        S_FETCH_DATA: begin
          if (!link_issued_reg) begin
            rd_start_reg    <= 1'b1;
            link_issued_reg <= 1'b1;
          end else if (link_done) begin
            link_issued_reg <= 1'b0;
            reg_wdata_reg   <= link_rdata;
            state_reg       <= S_REG_WR;
          end
        end
        S_REG_WR: begin
          if (!reg_we_reg) begin
            reg_we_reg  <= 1'b1;
            tmo_cnt_reg <= '0;
          end else if (bus_done) begin
            reg_we_reg   <= 1'b0;
            if (!bus.reg_ack) status_reg[ST_TIMEOUT] <= 1'b1;
            word_cnt_reg <= word_cnt_reg + 12'd1;
            addr_reg     <= addr_reg + 16'd1;
            state_reg    <= last_word ? S_SEND_TRAIL : S_FETCH_DATA;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
          end
        end
        S_REG_RD: begin
          if (!reg_re_reg) begin
            reg_re_reg  <= 1'b1;
            tmo_cnt_reg <= '0;
          end else if (bus_done) begin
            reg_re_reg <= 1'b0;
            if (bus.reg_ack) begin
              reply_reg <= bus.reg_rdata;
            end else begin
              reply_reg               <= FILL_WORD;
              status_reg[ST_TIMEOUT]  <= 1'b1;
            end
            state_reg <= S_SEND_DATA;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
          end
        end
        S_SEND_DATA: begin
          if (!link_issued_reg) begin
            wr_start_reg    <= 1'b1;
            link_wdata_reg  <= reply_reg;
            link_issued_reg <= 1'b1;
          end else if (link_done) begin
            link_issued_reg <= 1'b0;
            word_cnt_reg    <= word_cnt_reg + 12'd1;
            addr_reg        <= addr_reg + 16'd1;
            state_reg       <= last_word ? S_SEND_TRAIL : S_REG_RD;
          end
        end
        S_SEND_TRAIL: begin
          if (!link_issued_reg) begin
            wr_start_reg    <= 1'b1;
            link_wdata_reg  <= {hdr_reg[HDR_OP_MSB:HDR_CNT_LSB], status_reg};
            link_issued_reg <= 1'b1;
          end else if (link_done) begin
            link_issued_reg <= 1'b0;
            cmd_count_reg   <= cmd_count_reg + 16'd1;
            if (status_reg != 16'd0) err_flag_reg <= 1'b1;
            state_reg       <= S_FETCH_HDR;
          end
        end
        default: state_reg <= S_FETCH_HDR;
      endcase
    end
  end

  assign bus.aux_address = 17'd0;
  assign bus.reg_addr    = addr_reg;
  assign bus.reg_wdata   = reg_wdata_reg;
  assign bus.reg_we      = reg_we_reg;
  assign bus.reg_re      = reg_re_reg;
  assign cmd_count       = cmd_count_reg;
  assign err_flag        = err_flag_reg;

endmodule

// File: tb/tb_aux_cmd_engine.sv
// Bench for aux_cmd_engine: aux_io and register-file models, a rule-based command
// model, a directed vector table, reset/stall sequences and randomized commands.
module tb_aux_cmd_engine;

  logic        clk;
  logic        reset;
  logic [15:0] cmd_count;
  logic        err_flag;

  aux_cmd_engine_if bus();

  aux_cmd_engine #(.TIMEOUT_CYCLES(255)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cmd_count (cmd_count),
    .err_flag  (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Host-side word source and reply sink, each index owned by a single process.
  logic [31:0] host_mem [0:1023];
  int          host_wr = 0;
  int          host_rd = 0;
  logic [31:0] reply_log [0:1023];
  int          rep_cnt = 0;
  logic [47:0] wr_log [0:1023];
  int          wr_cnt = 0;
  int          viol_cnt = 0;
  int          strobe_len = 0;

  int rd_stall = 1;
  int wr_stall = 1;
  int ack_lat  = 0;
  bit noack    = 1'b0;

  logic [31:0] cmd_data [0:7];
  int          exp_count = 0;
  bit          exp_err = 1'b0;

  // aux_io model: one-cycle requests, busy while serving, stalls while empty.
  int io_state = 0;
  int stall_left = 0;
  bit prev_req = 1'b0;
  initial begin
    bus.aux_busy      = 1'b0;
    bus.aux_data_read = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bus.aux_busy = 1'b0;
        io_state     = 0;
        prev_req     = 1'b0;
      end else begin
        if (bus.aux_read_req || bus.aux_write_req) begin
          if ((bus.aux_read_req && bus.aux_write_req) || bus.aux_busy || prev_req)
            viol_cnt++;
        end
        prev_req = bus.aux_read_req || bus.aux_write_req;
        case (io_state)
          0: begin
            if (bus.aux_read_req) begin
              bus.aux_busy = 1'b1;
              stall_left   = rd_stall;
              io_state     = 1;
            end else if (bus.aux_write_req) begin
              if (rep_cnt < 1024) reply_log[rep_cnt] = bus.aux_data_write;
              rep_cnt++;
              bus.aux_busy = 1'b1;
              stall_left   = wr_stall;
              io_state     = 2;
            end
          end
          1: begin
            if (stall_left > 1) stall_left--;
            else if (host_rd < host_wr) begin
              bus.aux_data_read = host_mem[host_rd];
              host_rd++;
              bus.aux_busy = 1'b0;
              io_state     = 0;
            end
          end
          default: begin
            if (stall_left > 1) stall_left--;
            else begin
              bus.aux_busy = 1'b0;
              io_state     = 0;
            end
          end
        endcase
      end
    end
  end

  // Register-file model: read value is addr ^ 0x5A5A, ack after ack_lat strobe cycles.
  int scyc = 0;
  initial begin
    bus.reg_ack   = 1'b0;
    bus.reg_rdata = '0;
    forever begin
      @(negedge clk);
      bus.reg_ack = 1'b0;
      if (!reset) scyc = 0;
      else if (bus.reg_we || bus.reg_re) begin
        if (!noack && scyc == ack_lat) begin
          bus.reg_ack   = 1'b1;
          bus.reg_rdata = {16'h0, bus.reg_addr ^ 16'h5A5A};
          if (bus.reg_we) begin
            if (wr_cnt < 1024) wr_log[wr_cnt] = {bus.reg_addr, bus.reg_wdata};
            wr_cnt++;
          end
        end
        scyc++;
        strobe_len = scyc;
      end else scyc = 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_req"}, 64'(bus.aux_read_req), 64'd0);
    check({tag, "_wr_req"}, 64'(bus.aux_write_req), 64'd0);
    check({tag, "_dwrite"}, 64'(bus.aux_data_write), 64'd0);
    check({tag, "_aaddr"}, 64'(bus.aux_address), 64'd0);
    check({tag, "_raddr"}, 64'(bus.reg_addr), 64'd0);
    check({tag, "_rwdata"}, 64'(bus.reg_wdata), 64'd0);
    check({tag, "_we"}, 64'(bus.reg_we), 64'd0);
    check({tag, "_re"}, 64'(bus.reg_re), 64'd0);
    check({tag, "_count"}, 64'(cmd_count), 64'd0);
    check({tag, "_err"}, 64'(err_flag), 64'd0);
  endtask

  // Expected behaviour derived from the command rules, then compared with the logs.
  task automatic run_cmd(input logic [31:0] hdr, input bit use_tbl,
                         input logic [31:0] tbl_trl, input logic [31:0] tbl_r0,
                         input string tag);
    logic [3:0]  op;
    logic [11:0] n;
    logic [15:0] a;
    logic [15:0] st;
    logic [15:0] ai;
    logic [31:0] exp_rep[$];
    logic [47:0] exp_wr[$];
    int rep_base, wr_base, rd_base, viol_base, exp_reads, waited;
    op = hdr[31:28];
    n  = hdr[27:16];
    a  = hdr[15:0];
    st = 16'h0;
    if (op > 4'd2) st[0] = 1'b1;
    else if (op != 4'd0 && n == 12'd0) st[2] = 1'b1;
    else if (op != 4'd0 && noack) st[1] = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      ai = a + 16'(i);
      if (op == 4'd2) exp_rep.push_back(noack ? 32'hDEAD_DEAD : {16'h0, ai ^ 16'h5A5A});
      if (op == 4'd1 && !noack) exp_wr.push_back({ai, cmd_data[i]});
    end
    exp_rep.push_back({hdr[31:16], st});
    exp_reads = 1 + ((op == 4'd1) ? int'(n) : 0);
    exp_count++;
    if (st != 16'h0) exp_err = 1'b1;

    rep_base  = rep_cnt;
    wr_base   = wr_cnt;
    rd_base   = host_rd;
    viol_base = viol_cnt;
    host_mem[host_wr] = hdr;
    host_wr++;
    if (op == 4'd1) begin
      for (int i = 0; i < int'(n); i++) begin
        host_mem[host_wr] = cmd_data[i];
        host_wr++;
      end
    end

    waited = 0;
    while ((cmd_count != exp_count[15:0] || (rep_cnt - rep_base) < exp_rep.size())
           && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);

    check({tag, "_done"}, 64'(waited < 4000), 64'd1);
    check({tag, "_nreply"}, 64'(rep_cnt - rep_base), 64'(exp_rep.size()));
    for (int i = 0; i < exp_rep.size(); i++)
      check({tag, "_reply"}, 64'(reply_log[(rep_base + i) % 1024]), 64'(exp_rep[i]));
    if (use_tbl) begin
      check({tag, "_trailer"}, 64'(reply_log[(rep_base + exp_rep.size() - 1) % 1024]), 64'(tbl_trl));
      check({tag, "_first"}, 64'(reply_log[rep_base % 1024]), 64'(tbl_r0));
    end
    check({tag, "_nwrite"}, 64'(wr_cnt - wr_base), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      check({tag, "_write"}, 64'(wr_log[(wr_base + i) % 1024]), 64'(exp_wr[i]));
    check({tag, "_reads"}, 64'(host_rd - rd_base), 64'(exp_reads));
    check({tag, "_count"}, 64'(cmd_count), 64'(exp_count[15:0]));
    check({tag, "_err"}, 64'(err_flag), 64'(exp_err));
    check({tag, "_proto"}, 64'(viol_cnt - viol_base), 64'd0);
    $display("cmd %s hdr=%h trailer=%h count=%0d err=%0b", tag, hdr,
             reply_log[(rep_cnt + 1023) % 1024], cmd_count, err_flag);
  endtask

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] d0;
    logic [31:0] d1;
    int          lat;
    int          stall;
    bit          nak;
    logic [31:0] trl;
    logic [31:0] r0;
  } vec_t;

  vec_t tbl [0:6];

  initial begin
    int          sel;
    int          waited;
    logic [3:0]  op;
    logic [11:0] n;
    logic [15:0] a;

    tbl[0] = '{32'h1002_0010, 32'hAAAA_0001, 32'hAAAA_0002, 0, 1, 1'b0, 32'h1002_0000, 32'h1002_0000};
    tbl[1] = '{32'h2003_FFFE, 32'h0, 32'h0, 1, 2, 1'b0, 32'h2003_0000, 32'h0000_A5A4};
    tbl[2] = '{32'h2001_0040, 32'h0, 32'h0, 0, 1, 1'b1, 32'h2001_0002, 32'hDEAD_DEAD};
    tbl[3] = '{32'h7005_0000, 32'h0, 32'h0, 0, 1, 1'b0, 32'h7005_0001, 32'h7005_0001};
    tbl[4] = '{32'h1000_0000, 32'h0, 32'h0, 0, 1, 1'b0, 32'h1000_0004, 32'h1000_0004};
    tbl[5] = '{32'h0123_4567, 32'h0, 32'h0, 0, 50, 1'b0, 32'h0123_0000, 32'h0123_0000};
    tbl[6] = '{32'h1001_0020, 32'h1234_5678, 32'h0, 0, 1, 1'b1, 32'h1001_0002, 32'h1001_0002};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("init");
    reset = 1'b1;

    for (int v = 0; v < 7; v++) begin
      cmd_data[0] = tbl[v].d0;
      cmd_data[1] = tbl[v].d1;
      ack_lat  = tbl[v].lat;
      rd_stall = tbl[v].stall;
      wr_stall = tbl[v].stall;
      noack    = tbl[v].nak;
      run_cmd(tbl[v].hdr, 1'b1, tbl[v].trl, tbl[v].r0, $sformatf("vec%0d", v));
      if (tbl[v].nak) check($sformatf("vec%0d_strobe_len", v), 64'(strobe_len), 64'd255);
    end
    noack    = 1'b0;
    rd_stall = 1;
    wr_stall = 1;

    // Reset in the middle of a READ strobe, then a normal command.
    ack_lat = 20;
    host_mem[host_wr] = 32'h2003_0100;
    host_wr++;
    waited = 0;
    while (!bus.reg_re && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("midread_strobe_seen", 64'(bus.reg_re), 64'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("midread");
    exp_count = 0;
    exp_err   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ack_lat = 0;
    cmd_data[0] = 32'hAAAA_0001;
    cmd_data[1] = 32'hAAAA_0002;
    run_cmd(32'h1002_0010, 1'b1, 32'h1002_0000, 32'h1002_0000, "after_reset");

    for (int k = 0; k < 25; k++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0:       op = 4'd0;
        1:       op = 4'd1;
        2, 4:    op = 4'd2;
        default: op = 4'($urandom_range(3, 15));
      endcase
      n = 12'($urandom_range(0, 4));
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      for (int i = 0; i < 8; i++) cmd_data[i] = $urandom;
      ack_lat  = $urandom_range(0, 3);
      rd_stall = $urandom_range(1, 4);
      wr_stall = $urandom_range(1, 4);
      run_cmd({op, n, a}, 1'b0, 32'h0, 32'h0, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
